// File: rtl/dma_pkg.sv
// dma_pkg: constants shared by the DMA engine blocks.
package dma_pkg;

    localparam int DMA_BURST_BEATS = 8;
    localparam int DMA_BURST_BYTES = 32;
    localparam int DMA_FIFO_DEPTH  = 16;

endpackage

// File: rtl/dma_fifo_ram.sv
// dma_fifo_ram: simple dual-port storage with a registered, read-enabled output.
module dma_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    always_ff @(posedge clk)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/dma_data_fifo.sv
// dma_data_fifo: synchronous data FIFO between the DMA read and write paths.
// Define DMA_FIFO_ERR_EN to add sticky fifo_overflow/fifo_underflow outputs.
module dma_data_fifo
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = DMA_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   fifo_wen,
    input  logic [DATA_WIDTH-1:0]  fifo_wdata,
    input  logic                   fifo_rden,
    output logic [DATA_WIDTH-1:0]  fifo_rdata,
    output logic                   fifo_is_empty,
    output logic                   fifo_is_full,
`ifdef DMA_FIFO_ERR_EN
    output logic                   fifo_overflow,
    output logic                   fifo_underflow,
`endif
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr, rptr;
    logic        wr_ok, rd_ok;

    // Flags come only from registered pointers; requests never bypass them.
    assign fifo_count    = wptr - rptr;
    assign fifo_is_empty = wptr == rptr;
    assign fifo_is_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr_ok         = fifo_wen && !fifo_is_full && !clr && !rst;
    assign rd_ok         = fifo_rden && !fifo_is_empty && !clr && !rst;

    always_ff @(posedge clk)
        if (rst || clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
        end

    dma_fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wptr[AW-1:0]),
        .wdata (fifo_wdata),
        .re    (rd_ok),
        .raddr (rptr[AW-1:0]),
        .rdata (fifo_rdata)
    );

`ifdef DMA_FIFO_ERR_EN
    always_ff @(posedge clk)
        if (rst || clr) begin
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            if (fifo_wen && fifo_is_full) fifo_overflow <= 1'b1;
            if (fifo_rden && fifo_is_empty) fifo_underflow <= 1'b1;
        end
`endif

endmodule

// File: tb/tb_dma_data_fifo.sv
// tb_dma_data_fifo: directed and random stimulus against a queue-based FIFO model.
module tb_dma_data_fifo;

    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          fifo_wen = 1'b0;
    logic [DW-1:0] fifo_wdata = '0;
    logic          fifo_rden = 1'b0;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_is_empty;
    logic          fifo_is_full;
    logic [4:0]    fifo_count;
`ifdef DMA_FIFO_ERR_EN
    logic          fifo_overflow;
    logic          fifo_underflow;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata = '0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    dma_data_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .fifo_wen      (fifo_wen),
        .fifo_wdata    (fifo_wdata),
        .fifo_rden     (fifo_rden),
        .fifo_rdata    (fifo_rdata),
        .fifo_is_empty (fifo_is_empty),
        .fifo_is_full  (fifo_is_full),
`ifdef DMA_FIFO_ERR_EN
        .fifo_overflow (fifo_overflow),
        .fifo_underflow(fifo_underflow),
`endif
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic c = 1'b0, input logic rs = 1'b0);
        bit wa, ra;
        fifo_wen = w;
        fifo_wdata = d;
        fifo_rden = r;
        clr = c;
        rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_rdata = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wa = w && q.size() < DEPTH;
            ra = r && q.size() != 0;
            if (w && !wa) m_ovf = 1'b1;
            if (r && !ra) m_unf = 1'b1;
            if (ra) m_rdata = q.pop_front();
            if (wa) q.push_back(d);
        end
        #1;
        chk("count", DW'(fifo_count), DW'(q.size()));
        chk("empty", DW'(fifo_is_empty), DW'(q.size() == 0));
        chk("full", DW'(fifo_is_full), DW'(q.size() == DEPTH));
        chk("rdata", fifo_rdata, m_rdata);
`ifdef DMA_FIFO_ERR_EN
        chk("overflow", DW'(fifo_overflow), DW'(m_ovf));
        chk("underflow", DW'(fifo_underflow), DW'(m_unf));
`endif
    endtask

    initial begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("reset_count", DW'(fifo_count), 0);
        chk("reset_empty", DW'(fifo_is_empty), 1);
        chk("reset_rdata", fifo_rdata, 0);
        for (int i = 0; i < 8; i++) step(1, DW'(32'h11 + i), 0);
        chk("burst_count", DW'(fifo_count), 8);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1);
            chk("burst_rdata", fifo_rdata, DW'(32'h11 + i));
        end
        chk("burst_empty", DW'(fifo_is_empty), 1);
        step(0, 0, 1);
        chk("empty_read_hold", fifo_rdata, 32'h18);
`ifdef DMA_FIFO_ERR_EN
        chk("underflow_set", DW'(fifo_underflow), 1);
`endif
        for (int i = 0; i < DEPTH; i++) step(1, $urandom, 0);
        step(1, 32'hDEAD, 0);
        chk("full_count", DW'(fifo_count), 16);
        chk("full_flag", DW'(fifo_is_full), 1);
`ifdef DMA_FIFO_ERR_EN
        chk("overflow_set", DW'(fifo_overflow), 1);
`endif
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1);
        step(1, $urandom, 1);
        chk("empty_rw_count", DW'(fifo_count), 1);
        for (int i = 0; i < DEPTH - 1; i++) step(1, $urandom, 0);
        step(1, $urandom, 1);
        chk("full_rw_count", DW'(fifo_count), 15);
        for (int i = 0; i < 10; i++) step(0, 0, 1);
        for (int i = 0; i < 40; i++) step(1, $urandom, 1);
        chk("steady_count", DW'(fifo_count), 5);
        for (int i = 0; i < 5; i++) step(1, $urandom, 0);
        step(1, $urandom, 1, 1, 0);
        chk("clr_count", DW'(fifo_count), 0);
        chk("clr_empty", DW'(fifo_is_empty), 1);
        for (int i = 0; i < 10; i++) step(1, $urandom, 0);
        step(1, $urandom, 1, 1, 1);
        chk("rst_count", DW'(fifo_count), 0);
        chk("rst_rdata", fifo_rdata, 0);
        for (int i = 0; i < 600; i++) begin
            automatic int bias = ((i / 64) % 2) != 0 ? 3 : 1;
            step($urandom_range(0, 3) < bias, $urandom, $urandom_range(0, 3) >= bias - 1,
                 $urandom_range(0, 63) == 0, 1'b0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
